// File: rtl/gate_pkg.sv
// Constants shared by the gate datapath and its result FIFO.
// Also small sizing helpers so every file derives widths the same way.
package gate_pkg;

  localparam int GATE_WIDTH = 5;
  localparam int FIFO_DEPTH = 4;

  // Pointer width for a power-of-two depth.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent the full value DEPTH.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gate_result_fifo_if.sv
// Producer/consumer bus between the upstream gate, the result FIFO and
// whatever drains it.
interface gate_result_fifo_if
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH
);

  // A word moves on a rising edge only when its valid and ready are both high.
  // A valid that is not accepted is not a transfer. in_ready depends only on
  // registered FIFO state, so it never combinationally depends on out_ready.
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/gate_fifo_ptr.sv
// Wrap-around FIFO pointer: async reset, synchronous clear, increment enable.
// The depth is a power of two, so natural binary overflow provides the wrap.
module gate_fifo_ptr
  import gate_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         inc,
  output logic [fifo_ptr_w(DEPTH)-1:0] ptr
);

  localparam int PW = fifo_ptr_w(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // The clear takes priority over the increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/gate_result_fifo.sv
// Small flop-based FIFO that buffers gate result words. Occupancy comes from
// registered state only, and the sticky overflow flag records dropped words.
module gate_result_fifo
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  gate_result_fifo_if.slave            bus,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output logic                         overflow
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Pop is gated by registered emptiness, so a word written on this edge
  // cannot leave on the same edge.
  assign push = bus.in_valid && !full && !flush;
  assign pop  = !empty && bus.out_ready && !flush;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr];
  assign count         = count_q;
  assign overflow      = overflow_q;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // An offer while full is dropped but always recorded, even with a pop.
      if (bus.in_valid && full) begin
        overflow_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr] = bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; validity is defined by pointers and count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  gate_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  gate_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

endmodule
